// File: rtl/alu_seq_if.sv
// alu_seq_if: operand/result bundle for alu_seq.
//   master side (register file / issue logic) drives in_valid, a, b, op_code
//   and observes in_ready plus the registered result and flags.
//   slave side (alu_seq) is the mirror image.
//   WIDTH must match the WIDTH of the alu_seq instance it connects to.
interface alu_seq_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [3:0]       op_code;
    logic             out_valid;
    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] result_hi;
    logic             zero_flag;
    logic             carry_flag;
    logic             overflow_flag;
    logic             neg_flag;
    logic             illegal_op;

    modport master (
        output in_valid, a, b, op_code,
        input  in_ready, out_valid, result, result_hi,
               zero_flag, carry_flag, overflow_flag, neg_flag, illegal_op
    );

    modport slave (
        input  in_valid, a, b, op_code,
        output in_ready, out_valid, result, result_hi,
               zero_flag, carry_flag, overflow_flag, neg_flag, illegal_op
    );
endinterface

// File: rtl/alu_seq.sv
// alu_seq: sequential WIDTH-bit ALU with registered results and flags.
//   Single-cycle ops (add/sub/logic/shifts) register their result on the
//   accept edge; unsigned MUL runs an iterative shift-add over WIDTH cycles.
// Ports:
//   clk     system clock, all state on the rising edge
//   reset   synchronous active-high reset, overrides enable
//   enable  global stall: low freezes all state and blocks accepts
//   bus     alu_seq_if.slave: in_valid/in_ready handshake, a, b, op_code,
//           out_valid pulse, result, result_hi, flags, illegal_op
//
// state  | meaning
// S_IDLE | ready; single-cycle ops complete here, MUL starts here
// S_MUL  | shift-add iteration, cnt_q counts 0..WIDTH-1
// S_DONE | publish MUL result/flags, pulse out_valid
module alu_seq #(
    parameter int WIDTH = 16,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    alu_seq_if.slave    bus
);

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_AND = 4'b0010;
    localparam logic [3:0] OP_OR  = 4'b0011;
    localparam logic [3:0] OP_XOR = 4'b0100;
    localparam logic [3:0] OP_NOT = 4'b0101;
    localparam logic [3:0] OP_SHL = 4'b0110;
    localparam logic [3:0] OP_SHR = 4'b0111;
    localparam logic [3:0] OP_SRA = 4'b1000;
    localparam logic [3:0] OP_MUL = 4'b1001;

    localparam logic [SHW-1:0] CNT_LAST = SHW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic             accept;

    logic [SHW-1:0]   cnt_q;
    logic [WIDTH-1:0] mcand_q;
    // {partial high half, multiplier bits still to consume / low product bits}
    logic [2*WIDTH-1:0] prod_q;
    logic [WIDTH:0]   mul_sum;

    logic             out_valid_q;
    logic [WIDTH-1:0] result_q;
    logic [WIDTH-1:0] result_hi_q;
    logic             zero_q;
    logic             carry_q;
    logic             overflow_q;
    logic             neg_q;
    logic             illegal_q;

    // single-cycle datapath
    logic [SHW-1:0]   shamt;
    logic [WIDTH:0]   add_w;
    logic [WIDTH:0]   sub_w;
    logic [WIDTH:0]   shl_w;
    logic [WIDTH:0]   shr_w;
    logic [WIDTH:0]   sra_w;
    logic [WIDTH-1:0] alu_res;
    logic             alu_carry;
    logic             alu_ovf;
    logic             alu_ill;

    assign accept = enable & bus.in_valid & (state_q == S_IDLE);

    // ---------------- FSM ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (enable) begin
            case (state_q)
                S_IDLE: if (accept && bus.op_code == OP_MUL) state_d = S_MUL;
                S_MUL:  if (cnt_q == CNT_LAST) state_d = S_DONE;
                S_DONE: state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // ---------------- single-cycle ALU ----------------
    always_comb begin
        shamt = bus.b[SHW-1:0];
        add_w = {1'b0, bus.a} + {1'b0, bus.b};
        sub_w = {1'b0, bus.a} - {1'b0, bus.b};
        // Extra guard bit on the shifted-out side catches the last bit lost;
        // with a zero shift amount that bit is the padding zero, so carry=0.
        shl_w = {1'b0, bus.a} << shamt;
        shr_w = {bus.a, 1'b0} >> shamt;
        sra_w = (WIDTH+1)'($signed({bus.a, 1'b0}) >>> shamt);

        alu_res   = '0;
        alu_carry = 1'b0;
        alu_ovf   = 1'b0;
        alu_ill   = 1'b0;
        case (bus.op_code)
            OP_ADD: begin
                alu_res   = add_w[WIDTH-1:0];
                alu_carry = add_w[WIDTH];
                alu_ovf   = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) &&
                            (add_w[WIDTH-1] != bus.a[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res   = sub_w[WIDTH-1:0];
                alu_carry = sub_w[WIDTH];   // borrow: a < b unsigned
                alu_ovf   = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) &&
                            (sub_w[WIDTH-1] != bus.a[WIDTH-1]);
            end
            OP_AND: alu_res = bus.a & bus.b;
            OP_OR:  alu_res = bus.a | bus.b;
            OP_XOR: alu_res = bus.a ^ bus.b;
            OP_NOT: alu_res = ~bus.a;
            OP_SHL: begin
                alu_res   = shl_w[WIDTH-1:0];
                alu_carry = shl_w[WIDTH];
            end
            OP_SHR: begin
                alu_res   = shr_w[WIDTH:1];
                alu_carry = shr_w[0];
            end
            OP_SRA: begin
                alu_res   = sra_w[WIDTH:1];
                alu_carry = sra_w[0];
            end
            OP_MUL: alu_res = '0;           // handled by the iterative path
            default: alu_ill = 1'b1;
        endcase
    end

    // ---------------- shift-add multiplier step ----------------
    assign mul_sum = {1'b0, prod_q[2*WIDTH-1:WIDTH]} +
                     {1'b0, (prod_q[0] ? mcand_q : {WIDTH{1'b0}})};

    // ---------------- datapath / output registers ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q       <= '0;
            mcand_q     <= '0;
            prod_q      <= '0;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            result_hi_q <= '0;
            zero_q      <= 1'b0;
            carry_q     <= 1'b0;
            overflow_q  <= 1'b0;
            neg_q       <= 1'b0;
            illegal_q   <= 1'b0;
        end else if (!enable) begin
            // stalled cycles never show a pulse; everything else holds
            out_valid_q <= 1'b0;
        end else begin
            out_valid_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        if (bus.op_code == OP_MUL) begin
                            mcand_q <= bus.a;
                            prod_q  <= {{WIDTH{1'b0}}, bus.b};
                            cnt_q   <= '0;
                        end else begin
                            out_valid_q <= 1'b1;
                            result_q    <= alu_res;
                            result_hi_q <= '0;
                            zero_q      <= (alu_res == '0);
                            carry_q     <= alu_carry;
                            overflow_q  <= alu_ovf;
                            neg_q       <= alu_res[WIDTH-1];
                            illegal_q   <= alu_ill;
                        end
                    end
                end
                S_MUL: begin
                    prod_q <= {mul_sum, prod_q[WIDTH-1:1]};
                    cnt_q  <= cnt_q + 1'b1;
                end
                S_DONE: begin
                    out_valid_q <= 1'b1;
                    result_q    <= prod_q[WIDTH-1:0];
                    result_hi_q <= prod_q[2*WIDTH-1:WIDTH];
                    zero_q      <= (prod_q[WIDTH-1:0] == '0);
                    carry_q     <= (prod_q[2*WIDTH-1:WIDTH] != '0);
                    overflow_q  <= (prod_q[2*WIDTH-1:WIDTH] != '0);
                    neg_q       <= prod_q[WIDTH-1];
                    illegal_q   <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready      = (state_q == S_IDLE);
    assign bus.out_valid     = out_valid_q;
    assign bus.result        = result_q;
    assign bus.result_hi     = result_hi_q;
    assign bus.zero_flag     = zero_q;
    assign bus.carry_flag    = carry_q;
    assign bus.overflow_flag = overflow_q;
    assign bus.neg_flag      = neg_q;
    assign bus.illegal_op    = illegal_q;

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed self-checking bench for alu_seq at WIDTH=16.
module tb_alu_seq;

    localparam int W = 16;

    logic clk;
    logic reset;
    logic enable;
    int   n_checks;
    int   n_fail;
    int   cyc;

    alu_seq_if #(.WIDTH(W)) bus ();

    alu_seq #(.WIDTH(W)) dut (
        .clk    (clk),
        .reset  (reset),
        .enable (enable),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [3:0] opc, input logic [W-1:0] va, input logic [W-1:0] vb);
        bus.in_valid = 1'b1;
        bus.op_code  = opc;
        bus.a        = va;
        bus.b        = vb;
    endtask

    task automatic check_flags(input string tag, input logic z, input logic c,
                               input logic v, input logic n, input logic il);
        check({tag, ".zero"},    32'(bus.zero_flag),     32'(z));
        check({tag, ".carry"},   32'(bus.carry_flag),    32'(c));
        check({tag, ".ovf"},     32'(bus.overflow_flag), 32'(v));
        check({tag, ".neg"},     32'(bus.neg_flag),      32'(n));
        check({tag, ".illegal"}, 32'(bus.illegal_op),    32'(il));
    endtask

    // Waits for out_valid, counting ticks; cyc carries ticks already spent.
    task automatic wait_out(input int limit);
        while (!bus.out_valid && cyc < limit) begin
            tick();
            cyc++;
        end
    endtask

    initial begin
        n_checks     = 0;
        n_fail       = 0;
        reset        = 1'b1;
        enable       = 1'b1;
        bus.in_valid = 1'b0;
        bus.op_code  = 4'h0;
        bus.a        = '0;
        bus.b        = '0;
        tick();
        tick();
        reset = 1'b0;

        // reset state
        check("rst.in_ready",  32'(bus.in_ready),  32'd1);
        check("rst.out_valid", 32'(bus.out_valid), 32'd0);
        check("rst.result",    32'(bus.result),    32'd0);
        check("rst.result_hi", 32'(bus.result_hi), 32'd0);
        check_flags("rst", 0, 0, 0, 0, 0);

        // ADD wrap to zero
        drive(4'b0000, 16'hFFFF, 16'h0001);
        tick();
        bus.in_valid = 1'b0;
        check("add.out_valid", 32'(bus.out_valid), 32'd1);
        check("add.result",    32'(bus.result),    32'h0000);
        check_flags("add", 1, 1, 0, 0, 0);

        // SUB overflow then back-to-back SUB with borrow
        drive(4'b0001, 16'h8000, 16'h0001);
        tick();
        check("sub1.out_valid", 32'(bus.out_valid), 32'd1);
        check("sub1.in_ready",  32'(bus.in_ready),  32'd1);
        check("sub1.result",    32'(bus.result),    32'h7FFF);
        check_flags("sub1", 0, 0, 1, 0, 0);
        drive(4'b0001, 16'h0001, 16'h0002);
        tick();
        bus.in_valid = 1'b0;
        check("sub2.out_valid", 32'(bus.out_valid), 32'd1);
        check("sub2.result",    32'(bus.result),    32'hFFFF);
        check_flags("sub2", 0, 1, 0, 1, 0);
        tick();
        check("idle.out_valid", 32'(bus.out_valid), 32'd0);
        check("idle.hold",      32'(bus.result),    32'hFFFF);

        // shifts
        drive(4'b1000, 16'h8010, 16'h0005);
        tick();
        check("sra.result", 32'(bus.result), 32'hFC00);
        check_flags("sra", 0, 1, 0, 1, 0);
        drive(4'b0110, 16'h8001, 16'h0001);
        tick();
        check("shl.result", 32'(bus.result),     32'h0002);
        check("shl.carry",  32'(bus.carry_flag), 32'd1);
        drive(4'b0111, 16'hABCD, 16'h0000);
        tick();
        check("shr0.result", 32'(bus.result),     32'hABCD);
        check("shr0.carry",  32'(bus.carry_flag), 32'd0);
        // only b[3:0] is the amount: 0x14 shifts by 4
        drive(4'b0111, 16'h00F8, 16'h0014);
        tick();
        bus.in_valid = 1'b0;
        check("shr4.result", 32'(bus.result),     32'h000F);
        check("shr4.carry",  32'(bus.carry_flag), 32'd1);

        // MUL with an ignored request while busy
        drive(4'b1001, 16'h1234, 16'h0100);
        tick();
        cyc = 0;
        check("mul.busy0", 32'(bus.in_ready), 32'd0);
        drive(4'b0000, 16'h0001, 16'h0001);
        tick();
        cyc++;
        check("mul.busy1",    32'(bus.in_ready),  32'd0);
        check("mul.no_early", 32'(bus.out_valid), 32'd0);
        tick();
        cyc++;
        bus.in_valid = 1'b0;
        for (int i = 3; i <= 15; i++) begin
            tick();
            cyc++;
        end
        check("mul.busy15", 32'(bus.in_ready), 32'd0);
        wait_out(40);
        check("mul.latency",   32'(cyc),           32'd17);
        check("mul.result",    32'(bus.result),    32'h3400);
        check("mul.result_hi", 32'(bus.result_hi), 32'h0012);
        check_flags("mul", 0, 1, 1, 0, 0);
        check("mul.in_ready",  32'(bus.in_ready),  32'd1);
        tick();
        check("mul.pulse_end", 32'(bus.out_valid), 32'd0);
        check("mul.hold_hi",   32'(bus.result_hi), 32'h0012);

        // small MUL: high half zero
        drive(4'b1001, 16'h0003, 16'h0005);
        tick();
        bus.in_valid = 1'b0;
        cyc = 0;
        wait_out(40);
        check("mulsm.latency",   32'(cyc),           32'd17);
        check("mulsm.result",    32'(bus.result),    32'h000F);
        check("mulsm.result_hi", 32'(bus.result_hi), 32'h0000);
        check("mulsm.carry",     32'(bus.carry_flag), 32'd0);

        // MUL stalled 3 cycles
        drive(4'b1001, 16'hFFFF, 16'hFFFF);
        tick();
        bus.in_valid = 1'b0;
        cyc = 0;
        repeat (5) begin
            tick();
            cyc++;
        end
        enable = 1'b0;
        repeat (3) begin
            tick();
            cyc++;
        end
        check("stall.in_ready",  32'(bus.in_ready),  32'd0);
        check("stall.out_valid", 32'(bus.out_valid), 32'd0);
        enable = 1'b1;
        wait_out(40);
        check("stall.latency",   32'(cyc),           32'd20);
        check("stall.result",    32'(bus.result),    32'h0001);
        check("stall.result_hi", 32'(bus.result_hi), 32'hFFFE);
        check_flags("stall", 0, 1, 1, 0, 0);

        // reset during MUL
        drive(4'b1001, 16'h1234, 16'h0100);
        tick();
        bus.in_valid = 1'b0;
        repeat (7) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("abort.in_ready",  32'(bus.in_ready),  32'd1);
        check("abort.out_valid", 32'(bus.out_valid), 32'd0);
        check("abort.result",    32'(bus.result),    32'd0);
        check("abort.result_hi", 32'(bus.result_hi), 32'd0);
        check_flags("abort", 0, 0, 0, 0, 0);
        cyc = 0;
        wait_out(20);
        check("abort.no_pulse", 32'(bus.out_valid), 32'd0);

        // illegal opcode then legal AND
        drive(4'b1111, 16'h0005, 16'h0003);
        tick();
        check("ill.out_valid", 32'(bus.out_valid), 32'd1);
        check("ill.result",    32'(bus.result),    32'd0);
        check_flags("ill", 1, 0, 0, 0, 1);
        drive(4'b0010, 16'hF0F0, 16'h0FF0);
        tick();
        bus.in_valid = 1'b0;
        check("and.out_valid", 32'(bus.out_valid), 32'd1);
        check("and.result",    32'(bus.result),    32'h00F0);
        check_flags("and", 0, 0, 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
